// File: rtl/pos_mask_decoder_if.sv
// Handshake bus for pos_mask_decoder.
// Input side : in_valid / in_ready carry one beat of {pos, last}.
// Output side: out_valid / out_ready carry one frame result of {mask, count, dup}.
// master : the producer/consumer environment around the decoder.
// slave  : the decoder itself.
interface pos_mask_decoder_if;
    localparam int unsigned POS_W   = 2;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned COUNT_W = 3;

    logic               in_valid;
    logic               in_ready;
    logic [POS_W-1:0]   pos;
    logic               last;
    logic               out_valid;
    logic               out_ready;
    logic [MASK_W-1:0]  mask;
    logic [COUNT_W-1:0] count;
    logic               dup;

    modport master (
        output in_valid, pos, last, out_ready,
        input  in_ready, out_valid, mask, count, dup
    );

    modport slave (
        input  in_valid, pos, last, out_ready,
        output in_ready, out_valid, mask, count, dup
    );
endinterface

// File: rtl/pos_mask_decoder.sv
// Frame position-mask decoder.
// Accumulates the one-hot decode of pos over the beats of a frame (terminated by
// last), counting beats (saturating at 7) and flagging repeated positions. The
// frame result is registered and held until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - slave side of pos_mask_decoder_if (beat input, frame result output)
module pos_mask_decoder (
    input  logic                clk,
    input  logic                reset,
    pos_mask_decoder_if.slave   bus
);
    localparam int unsigned POS_W   = 2;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned COUNT_W = 3;
    localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [MASK_W-1:0]  acc, acc_n;
    logic [COUNT_W-1:0] cnt, cnt_n;
    logic               dflag, dflag_n;

    logic               out_valid_q, out_valid_n;
    logic [MASK_W-1:0]  mask_q, mask_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic               dup_q, dup_n;

    logic [MASK_W-1:0]  onehot_c;
    logic               hit_c;
    logic [COUNT_W-1:0] cnt_inc_c;
    logic               in_ready_c;
    logic               accept_c;

    // Beat decode and per-beat helpers
    always_comb begin
        onehot_c  = MASK_W'(1) << bus.pos;
        hit_c     = |(acc & onehot_c);
        cnt_inc_c = (cnt == CNT_MAX) ? CNT_MAX : cnt + COUNT_W'(1);
        // Ready depends only on state and reset, never on out_ready.
        in_ready_c = (state != EMIT) && !reset;
        accept_c   = bus.in_valid && in_ready_c;
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            dflag       <= 1'b0;
            out_valid_q <= 1'b0;
            mask_q      <= '0;
            count_q     <= '0;
            dup_q       <= 1'b0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            dflag       <= dflag_n;
            out_valid_q <= out_valid_n;
            mask_q      <= mask_n;
            count_q     <= count_n;
            dup_q       <= dup_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        dflag_n     = dflag;
        out_valid_n = out_valid_q;
        mask_n      = mask_q;
        count_n     = count_q;
        dup_n       = dup_q;

        case (state)
            IDLE, ACCUM: begin
                if (accept_c) begin
                    if (bus.last) begin
                        // Close the frame: publish result, clear accumulator.
                        mask_n      = acc | onehot_c;
                        count_n     = cnt_inc_c;
                        dup_n       = dflag | hit_c;
                        out_valid_n = 1'b1;
                        acc_n       = '0;
                        cnt_n       = '0;
                        dflag_n     = 1'b0;
                        state_n     = EMIT;
                    end else begin
                        acc_n   = acc | onehot_c;
                        cnt_n   = cnt_inc_c;
                        dflag_n = dflag | hit_c;
                        state_n = ACCUM;
                    end
                end
            end
            EMIT: begin
                // Result fields keep their values after the handshake.
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.mask      = mask_q;
    assign bus.count     = count_q;
    assign bus.dup       = dup_q;
endmodule

// File: tb/tb_pos_mask_decoder.sv
// Scoreboard bench for pos_mask_decoder: directed frames push expected results,
// a monitor pops and compares on every output handshake.
module tb_pos_mask_decoder;
    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] count;
        logic       dup;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycles   = 0;
    exp_t sb[$];

    pos_mask_decoder_if bus ();

    pos_mask_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (cycles > 5000) begin
            $display("FAIL watchdog: cycles=%0d required < 5000", cycles);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted frame result against the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: mask=%b count=%0d dup=%b, none expected",
                         bus.mask, bus.count, bus.dup);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_mask",  8'(bus.mask),  8'(e.mask));
                check("sb_count", 8'(bus.count), 8'(e.count));
                check("sb_dup",   8'(bus.dup),   8'(e.dup));
            end
        end
    end

    // Present one beat and return just after the edge that accepts it.
    task automatic send_beat(input logic [1:0] p, input logic l);
        int n;
        bus.in_valid = 1'b1;
        bus.pos      = p;
        bus.last     = l;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] p[$], input exp_t e);
        for (int i = 0; i < p.size(); i++) begin
            if (i == p.size() - 1) sb.push_back(e);
            send_beat(p[i], (i == p.size() - 1));
            @(negedge clk);
            check("latency_out_valid", 8'(bus.out_valid), 8'(i == p.size() - 1));
            if (i != p.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [1:0] fr[$];
        bus.in_valid  = 1'b0;
        bus.pos       = 2'd0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  8'(bus.in_ready),  8'd0);
        check("rst_out_valid", 8'(bus.out_valid), 8'd0);
        check("rst_mask",      8'(bus.mask),      8'd0);
        check("rst_count",     8'(bus.count),     8'd0);
        check("rst_dup",       8'(bus.dup),       8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 8'(bus.in_ready), 8'd1);
        @(posedge clk);
        #1;

        // Single beat pos=2
        fr = '{2'd2};
        send_frame(fr, '{mask: 4'b0100, count: 3'd1, dup: 1'b0});
        @(negedge clk);
        check("single_out_valid_clear", 8'(bus.out_valid), 8'd0);
        check("single_mask_kept",       8'(bus.mask),      8'h04);
        check("single_in_ready",        8'(bus.in_ready),  8'd1);
        @(posedge clk);
        #1;

        // Frame 0,3,1
        fr = '{2'd0, 2'd3, 2'd1};
        send_frame(fr, '{mask: 4'b1011, count: 3'd3, dup: 1'b0});
        @(posedge clk);
        #1;

        // Frame 1,1,2 with duplicate
        fr = '{2'd1, 2'd1, 2'd2};
        send_frame(fr, '{mask: 4'b0110, count: 3'd3, dup: 1'b1});
        @(posedge clk);
        #1;

        // 9-beat frame, count saturates
        fr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        send_frame(fr, '{mask: 4'b1111, count: 3'd7, dup: 1'b1});
        @(posedge clk);
        #1;

        // Back-pressure: hold result 5 cycles while a beat is offered
        bus.out_ready = 1'b0;
        sb.push_back('{mask: 4'b0010, count: 3'd1, dup: 1'b0});
        send_beat(2'd1, 1'b1);
        bus.in_valid = 1'b1;
        bus.pos      = 2'd3;
        bus.last     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 8'(bus.out_valid), 8'd1);
            check("bp_mask",      8'(bus.mask),      8'h02);
            check("bp_count",     8'(bus.count),     8'd1);
            check("bp_dup",       8'(bus.dup),       8'd0);
            check("bp_in_ready",  8'(bus.in_ready),  8'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release_out_valid", 8'(bus.out_valid), 8'd0);
        check("bp_release_in_ready",  8'(bus.in_ready),  8'd1);
        @(posedge clk);
        #1;

        // Reset mid-frame discards the partial frame
        send_beat(2'd0, 1'b0);
        send_beat(2'd1, 1'b0);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.pos      = 2'd2;
        bus.last     = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 8'(bus.in_ready), 8'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 8'(bus.out_valid), 8'd0);
        check("midrst_mask",      8'(bus.mask),      8'd0);
        @(posedge clk);
        #1;
        fr = '{2'd3};
        send_frame(fr, '{mask: 4'b1000, count: 3'd1, dup: 1'b0});

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
